microsequencer_stack: RTL

Second-generation microcode address sequencer. It keeps the existing operations: relative branch, conditional branch, fetch/trap dispatch and IR decode. It adds a parametrised return stack for micro-subroutines, a hardware loop counter, signed branch offsets, a generic condition vector and a stall input. It sits between the microcode ROM output register and the ROM address input, and produces the next micro-address each clock.

---
 rtl/microsequencer_stack_pkg.sv | 31 +++
 rtl/microsequencer_stack_return_stack.sv | 60 ++++++
 rtl/microsequencer_stack.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/microsequencer_stack_pkg.sv
// -----------------------------------------------------------------------------
// pa_useq : shared types and helpers for the microcode address sequencer.
//   seq_op_t    - sequencer operation encoding (3 bits)
//   sign_extend - sign-extends the low 'width' bits of a 32-bit value
// -----------------------------------------------------------------------------
package pa_useq;

    typedef enum logic [2:0] {
        BR   = 3'b000,
        CBR  = 3'b001,
        DISP = 3'b010,
        DEC  = 3'b011,
        CALL = 3'b100,
        RET  = 3'b101,
        LOOP = 3'b110,
        LDLP = 3'b111
    } seq_op_t;

    // Bit (width-1) of val is the sign; every bit above it is replaced by it.
    function automatic logic [31:0] sign_extend(input logic [31:0] val,
                                                input int unsigned width);
        logic [31:0] mask_s;
        mask_s = 32'hFFFF_FFFF << width;
        if (val[width-1]) begin
            return val | mask_s;
        end else begin
            return val & ~mask_s;
        end
    endfunction

endpackage

// File: rtl/microsequencer_stack_return_stack.sv
// -----------------------------------------------------------------------------
// useq_return_stack : LIFO return-address stack for micro-subroutines.
//   clk, arst   - clock, asynchronous active-high reset
//   push, pop   - push din / pop top (ignored when full / empty respectively)
//   din, dout   - entry to push, current top of stack (0 when empty)
//   level       - number of occupied entries
//   full, empty - occupancy status
// -----------------------------------------------------------------------------
module useq_return_stack
    import pa_useq::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 14,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_r [DEPTH];
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_m1_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;

    // Entry 'level' is the next free slot; entry 'level-1' is the top.
    assign level_m1_s = level_r - LVL_W'(1);
    assign wr_idx_s   = level_r[IDX_W-1:0];
    assign rd_idx_s   = level_m1_s[IDX_W-1:0];

    assign full  = (level_r == LVL_W'(DEPTH));
    assign empty = (level_r == {LVL_W{1'b0}});
    assign dout  = empty ? {W{1'b0}} : mem_r[rd_idx_s];
    assign level = level_r;

    // Stack storage and occupancy update.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            level_r <= {LVL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= din;
            level_r         <= level_r + LVL_W'(1);
        end else if (pop && !empty) begin
            level_r <= level_m1_s;
        end
    end

endmodule

// File: rtl/microsequencer_stack.sv
// -----------------------------------------------------------------------------
// microsequencer_stack : next micro-address generator with return stack,
// hardware loop counter, signed branches and a generic condition vector.
//   clk, arst           - clock, asynchronous active-high reset
//   stall               - freeze all state for this cycle
//   seq_op, offset      - operation (pa_useq::seq_op_t) and signed offset
//   cond_sel/invert/vec - condition selection; cond_true is combinational
//   ir                  - opcode for DEC (zero-extended)
//   fetch_addr/trap_addr, dma_req, int_pending - dispatch targets / requests
//   loop_load           - value loaded by LDLP
//   u_address, loop_count, stack_level, stack_ovf, stack_unf - state outputs
// Optional build macro USEQ_TRAP_ON_STACK_ERR_EN: a CALL overflow or RET
// underflow jumps to trap_addr instead of the normal target.
// -----------------------------------------------------------------------------
module microsequencer_stack
    import pa_useq::*;
#(
    parameter int UADDR_W     = 14,
    parameter int OFFSET_W    = 7,
    parameter int IR_W        = 8,
    parameter int NUM_COND    = 16,
    parameter int STACK_DEPTH = 4,
    parameter int LOOP_W      = 8
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             stall,
    input  logic [2:0]                       seq_op,
    input  logic [OFFSET_W-1:0]              offset,
    input  logic [$clog2(NUM_COND)-1:0]      cond_sel,
    input  logic                             cond_invert,
    input  logic [NUM_COND-1:0]              cond_vec,
    input  logic [IR_W-1:0]                  ir,
    input  logic [UADDR_W-1:0]               fetch_addr,
    input  logic [UADDR_W-1:0]               trap_addr,
    input  logic                             dma_req,
    input  logic                             int_pending,
    input  logic [LOOP_W-1:0]                loop_load,
    output logic [UADDR_W-1:0]               u_address,
    output logic                             cond_true,
    output logic [LOOP_W-1:0]                loop_count,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
    output logic                             stack_ovf,
    output logic                             stack_unf
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [UADDR_W-1:0] addr_r;
    logic [UADDR_W-1:0] addr_nxt_s;
    logic [UADDR_W-1:0] off_s;
    logic [UADDR_W-1:0] addr_inc_s;
    logic [UADDR_W-1:0] addr_br_s;
    logic [LOOP_W-1:0]  loop_r;
    logic [LOOP_W-1:0]  loop_nxt_s;
    logic               ovf_r;
    logic               unf_r;
    logic               set_ovf_s;
    logic               set_unf_s;
    logic               push_s;
    logic               pop_s;
    logic [UADDR_W-1:0] stk_dout_s;
    logic               stk_full_s;
    logic               stk_empty_s;

    assign off_s      = UADDR_W'(sign_extend(32'(offset), OFFSET_W));
    assign addr_inc_s = addr_r + UADDR_W'(1);
    assign addr_br_s  = addr_r + off_s;
    assign cond_true  = cond_vec[cond_sel] ^ cond_invert;

    // Next-state decode for every sequencer operation.
    always_comb begin
        addr_nxt_s = addr_inc_s;
        loop_nxt_s = loop_r;
        set_ovf_s  = 1'b0;
        set_unf_s  = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        case (seq_op_t'(seq_op))
            BR: begin
                addr_nxt_s = addr_br_s;
            end
            CBR: begin
                if (cond_true) begin
                    addr_nxt_s = addr_br_s;
                end else begin
                    addr_nxt_s = addr_inc_s;
                end
            end
            DISP: begin
                if (dma_req || int_pending) begin
                    addr_nxt_s = trap_addr;
                end else begin
                    addr_nxt_s = fetch_addr;
                end
            end
            DEC: begin
                addr_nxt_s = UADDR_W'(ir);
            end
            CALL: begin
                if (stk_full_s) begin
                    set_ovf_s = 1'b1;
`ifdef USEQ_TRAP_ON_STACK_ERR_EN
                    addr_nxt_s = trap_addr;
`else
                    addr_nxt_s = addr_br_s;
`endif
                end else begin
                    push_s     = 1'b1;
                    addr_nxt_s = addr_br_s;
                end
            end
            RET: begin
                if (stk_empty_s) begin
                    set_unf_s = 1'b1;
`ifdef USEQ_TRAP_ON_STACK_ERR_EN
                    addr_nxt_s = trap_addr;
`else
                    addr_nxt_s = fetch_addr;
`endif
                end else begin
                    pop_s      = 1'b1;
                    addr_nxt_s = stk_dout_s;
                end
            end
            LOOP: begin
                if (loop_r != {LOOP_W{1'b0}}) begin
                    loop_nxt_s = loop_r - LOOP_W'(1);
                    addr_nxt_s = addr_br_s;
                end else begin
                    addr_nxt_s = addr_inc_s;
                end
            end
            LDLP: begin
                loop_nxt_s = loop_load;
                addr_nxt_s = addr_inc_s;
            end
            default: begin
                addr_nxt_s = addr_inc_s;
            end
        endcase
    end

    // Stall must also freeze the stack, so push/pop are gated here.
    useq_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (UADDR_W),
        .LVL_W (LVL_W)
    ) u_stack (
        .clk   (clk),
        .arst  (arst),
        .push  (push_s & ~stall),
        .pop   (pop_s & ~stall),
        .din   (addr_inc_s),
        .dout  (stk_dout_s),
        .level (stack_level),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // Address, loop counter and sticky error flag registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            addr_r <= {UADDR_W{1'b0}};
            loop_r <= {LOOP_W{1'b0}};
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else if (!stall) begin
            addr_r <= addr_nxt_s;
            loop_r <= loop_nxt_s;
            ovf_r  <= ovf_r | set_ovf_s;
            unf_r  <= unf_r | set_unf_s;
        end
    end

    assign u_address  = addr_r;
    assign loop_count = loop_r;
    assign stack_ovf  = ovf_r;
    assign stack_unf  = unf_r;

endmodule
